// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU request/response port and 128-bit memory port of assoc_cache.
interface assoc_cache_if #(parameter int CPU_WIDTH = 32, parameter int WORD_ADDR_BITS = 30);
  logic cpu_req_valid;
  logic cpu_req_ready;
  logic [WORD_ADDR_BITS-1:0] cpu_req_addr;
  logic [CPU_WIDTH-1:0] cpu_req_data;
  logic [CPU_WIDTH/8-1:0] cpu_req_write;
  logic cpu_resp_valid;
  logic [CPU_WIDTH-1:0] cpu_resp_data;
  logic mem_req_valid;
  logic mem_req_ready;
  logic [WORD_ADDR_BITS-3:0] mem_req_addr;
  logic mem_req_rw;
  logic mem_req_data_valid;
  logic mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0] mem_req_data_mask;
  logic mem_resp_valid;
  logic [127:0] mem_resp_data;
  modport slave (
    input cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    input mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );
  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    input cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    input mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back cache, PLRU replacement, 4-beat 128-bit line transfers.
// Define ASSOC_CACHE_STATS_EN to add the stat_hits/stat_misses counters.
module assoc_cache #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int CPU_WIDTH = 32,
  parameter int WORD_ADDR_BITS = 30
) (
  input logic clk,
  input logic reset,
  assoc_cache_if.slave bus
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int SB = $clog2(SETS);
  localparam int TAG = WORD_ADDR_BITS - SB - 4;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int NB = CPU_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_CMD, WB_DATA, FILL_CMD, FILL_WAIT} state_t;
  state_t state, state_n;
  logic [TAG-1:0] tags [WAYS][SETS];
  logic [127:0] data [WAYS][SETS][4];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [WORD_ADDR_BITS-1:0] addr;
  logic [CPU_WIDTH-1:0] wdata;
  logic [NB-1:0] wmask;
  logic replay, dat_done, beat_done, hit, free, touch, fill_beat, fill_last;
  logic [1:0] beat;
  logic [WW-1:0] vway, hway, fway, victim, plru_way, touch_way;
  logic [SB-1:0] idx;
  logic [TAG-1:0] tag;
  logic [1:0] bsel, lane;
  assign tag = addr[WORD_ADDR_BITS-1:SB+4];
  assign idx = addr[SB+3:4];
  assign bsel = addr[3:2];
  assign lane = addr[1:0];
  always_comb begin
    hit = 1'b0;
    hway = '0;
    free = 1'b0;
    fway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tags[w][idx] == tag) begin
        hit = 1'b1;
        hway = WW'(w);
      end
      if (!valid[idx][w]) begin
        free = 1'b1;
        fway = WW'(w);
      end
    end
  end
  assign victim = free ? fway : plru_way;
  assign fill_beat = state == FILL_WAIT && bus.mem_resp_valid;
  assign fill_last = fill_beat && beat == 2'd3;
  assign touch = (state == LOOKUP && hit) || fill_last;
  assign touch_way = state == LOOKUP ? hway : vway;
  generate
    if (WAYS == 1) begin : g_dm
      assign plru_way = '0;
    end else begin : g_plru
      // Tree bits point at the victim: [0] picks the half, [1]/[2] the way within it.
      logic [2:0] plru [SETS];
      logic [2:0] p;
      logic [1:0] tw;
      assign p = plru[idx];
      assign tw = 2'(touch_way);
      assign plru_way = WW'(WAYS == 4 ? (p[0] ? {1'b1, p[2]} : {1'b0, p[1]}) : {1'b0, p[1]});
      always_ff @(posedge clk)
        if (reset)
          for (int s = 0; s < SETS; s++) plru[s] <= '0;
        else if (touch)
          plru[idx] <= {tw[1] ? tw == 2'd2 : p[2], tw[1] ? p[1] : tw == 2'd0, !tw[1]};
    end
  endgenerate
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    bus.cpu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw = 1'b0;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_addr = {tag, idx, beat};
    beat_done = 1'b0;
    case (state)
      IDLE: begin
        bus.cpu_req_ready = 1'b1;
        state_n = bus.cpu_req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        bus.cpu_req_ready = hit;
        state_n = hit ? (bus.cpu_req_valid ? LOOKUP : IDLE)
                : (valid[idx][victim] && dirty[idx][victim] ? WB_CMD : FILL_CMD);
      end
      WB_CMD: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw = 1'b1;
        bus.mem_req_addr = {tags[vway][idx], idx, beat};
        bus.mem_req_data_valid = !dat_done;
        beat_done = bus.mem_req_ready && (dat_done || bus.mem_req_data_ready);
        state_n = bus.mem_req_ready ? WB_DATA : WB_CMD;
      end
      WB_DATA: begin
        bus.mem_req_data_valid = 1'b1;
        beat_done = bus.mem_req_data_ready;
      end
      FILL_CMD: begin
        bus.mem_req_valid = 1'b1;
        state_n = bus.mem_req_ready ? FILL_WAIT : FILL_CMD;
      end
      FILL_WAIT: state_n = bus.mem_resp_valid ? (beat == 2'd3 ? LOOKUP : FILL_CMD) : FILL_WAIT;
      default: state_n = IDLE;
    endcase
    if (beat_done) state_n = beat == 2'd3 ? FILL_CMD : WB_CMD;
  end
  assign bus.mem_req_data_bits = data[vway][idx][beat];
  assign bus.mem_req_data_mask = 16'hFFFF;
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && |wmask)
      for (int b = 0; b < NB; b++)
        if (wmask[b]) data[hway][idx][bsel][lane * CPU_WIDTH + b * 8 +: 8] <= wdata[b * 8 +: 8];
    if (fill_beat) data[vway][idx][beat] <= bus.mem_resp_data;
    if (fill_last) tags[vway][idx] <= tag;
  end
  always_ff @(posedge clk) begin
    bus.cpu_resp_data <= data[hway][idx][bsel][lane * CPU_WIDTH +: CPU_WIDTH];
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
      bus.cpu_resp_valid <= 1'b0;
      replay <= 1'b0;
      beat <= '0;
      dat_done <= 1'b0;
      vway <= '0;
      addr <= '0;
      wdata <= '0;
      wmask <= '0;
    end else begin
      bus.cpu_resp_valid <= state == LOOKUP && hit && wmask == '0;
      if (bus.cpu_req_valid && bus.cpu_req_ready) begin
        addr <= bus.cpu_req_addr;
        wdata <= bus.cpu_req_data;
        wmask <= bus.cpu_req_write;
        replay <= 1'b0;
      end
      if (state == LOOKUP && hit && |wmask) dirty[idx][hway] <= 1'b1;
      if (state == LOOKUP && !hit) begin
        vway <= victim;
        beat <= '0;
        dat_done <= 1'b0;
      end
      if (state == WB_CMD && bus.mem_req_data_valid && bus.mem_req_data_ready) dat_done <= 1'b1;
      if (beat_done) begin
        beat <= beat + 2'd1;
        dat_done <= 1'b0;
      end
      if (fill_beat) beat <= beat + 2'd1;
      if (fill_last) begin
        valid[idx][vway] <= 1'b1;
        dirty[idx][vway] <= 1'b0;
        replay <= 1'b1;
      end
    end
  end
`ifdef ASSOC_CACHE_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP && !replay) begin
      stat_hits <= stat_hits + 32'(hit);
      stat_misses <= stat_misses + 32'(!hit);
    end
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed tests of assoc_cache (WAYS=2) against a behavioural 128-bit memory.
module tb_assoc_cache;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  int ddly = 0;
  int rcnt = 0;
  int dcnt = 0;
  logic [28:0] cmd_log [$];
  logic [27:0] rd_q [$];
  logic [27:0] wa_q [$];
  logic [127:0] wd_log [$];
  logic [15:0] wm_log [$];
  logic [127:0] wmem [logic [27:0]];
  assoc_cache_if bus ();
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  assoc_cache dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Untouched memory word at word address wa reads as 0x1000_0000 + wa.
  function automatic logic [127:0] line(input logic [27:0] a);
    logic [127:0] v;
    if (wmem.exists(a)) return wmem[a];
    for (int k = 0; k < 4; k++) v[k * 32 +: 32] = 32'h1000_0000 + 32'({a, 2'(k)});
    return v;
  endfunction
  initial begin
    bus.mem_req_ready = 1'b1;
    bus.mem_req_data_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_data_ready = 1'b0;
      if (reset) begin
        rd_q.delete();
        wa_q.delete();
        rcnt = 0;
        dcnt = 0;
      end else begin
        if (rd_q.size() > 0) begin
          if (rcnt == 2) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data = line(rd_q.pop_front());
            rcnt = 0;
          end else rcnt++;
        end
        if (bus.mem_req_valid) begin
          cmd_log.push_back({bus.mem_req_rw, bus.mem_req_addr});
          if (bus.mem_req_rw) wa_q.push_back(bus.mem_req_addr);
          else rd_q.push_back(bus.mem_req_addr);
        end
        if (bus.mem_req_data_valid) begin
          if (dcnt >= ddly) begin
            bus.mem_req_data_ready = 1'b1;
            dcnt = 0;
            wd_log.push_back(bus.mem_req_data_bits);
            wm_log.push_back(bus.mem_req_data_mask);
            if (wa_q.size() > 0) wmem[wa_q.pop_front()] = bus.mem_req_data_bits;
          end else dcnt++;
        end else dcnt = 0;
      end
    end
  end
  task automatic access(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output int lat);
    int n = 0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr = a;
    bus.cpu_req_data = d;
    bus.cpu_req_write = m;
    while (!bus.cpu_req_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    lat = 1;
    while (m == 4'h0 && !bus.cpu_resp_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.cpu_resp_data;
    check("handshake_timeout", 1'(n >= 2000 || lat >= 2000), 1'b0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.cpu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    int lat, s, ws, n;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr = '0;
    bus.cpu_req_data = '0;
    bus.cpu_req_write = '0;
    reset = 1'b1;
    @(posedge clk);
    do_reset();
    check("rst_req_ready", bus.cpu_req_ready, 1'b1);
    check("rst_resp_valid", bus.cpu_resp_valid, 1'b0);
    check("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_rw", bus.mem_req_rw, 1'b0);
    check("rst_data_valid", bus.mem_req_data_valid, 1'b0);
    s = cmd_log.size();
    access(30'h100, '0, 4'h0, rd, lat);
    check("t1_miss_data", rd, 32'h1000_0100);
    check("t1_miss_slow", 1'(lat > 2), 1'b1);
    check("t1_fill_cmds", cmd_log.size() - s, 4);
    for (int i = 0; i < 4; i++) check("t1_fill_addr", cmd_log[s + i], {1'b0, 28'h40 + 28'(i)});
    access(30'h100, '0, 4'h0, rd, lat);
    check("t1_hit_data", rd, 32'h1000_0100);
    check("t1_hit_latency", lat, 2);
    s = cmd_log.size();
    access(30'h100, 32'hDEAD_BEEF, 4'b0011, rd, lat);
    access(30'h100, '0, 4'h0, rd, lat);
    check("t2_fwd_data", rd, 32'h1000_BEEF);
    check("t2_fwd_latency", lat, 2);
    access(30'h101, '0, 4'h0, rd, lat);
    check("t2_neighbour", rd, 32'h1000_0101);
    check("t2_no_mem", cmd_log.size() - s, 0);
    access(30'h400, '0, 4'h0, rd, lat);
    check("t3_a_fill", rd, 32'h1000_0400);
    access(30'h800, '0, 4'h0, rd, lat);
    check("t3_b_fill", rd, 32'h1000_0800);
    access(30'h400, '0, 4'h0, rd, lat);
    check("t3_a_touch", lat, 2);
    access(30'hC00, '0, 4'h0, rd, lat);
    check("t3_c_data", rd, 32'h1000_0C00);
    check("t3_c_miss", 1'(lat > 2), 1'b1);
    access(30'h400, '0, 4'h0, rd, lat);
    check("t3_a_still_hit", lat, 2);
    check("t3_a_data", rd, 32'h1000_0400);
    access(30'h800, '0, 4'h0, rd, lat);
    check("t3_b_evicted", 1'(lat > 2), 1'b1);
    ddly = 3;
    access(30'h10, '0, 4'h0, rd, lat);
    access(30'h11, 32'hCAFE_F00D, 4'hF, rd, lat);
    access(30'h410, '0, 4'h0, rd, lat);
    check("t4_second_way", rd, 32'h1000_0410);
    s = cmd_log.size();
    ws = wd_log.size();
    access(30'h810, '0, 4'h0, rd, lat);
    check("t4_new_data", rd, 32'h1000_0810);
    check("t4_wb_beats", wd_log.size() - ws, 4);
    for (int i = 0; i < 4; i++) check("t4_wb_cmd", cmd_log[s + i], {1'b1, 28'h4 + 28'(i)});
    for (int i = 0; i < 4; i++) check("t4_fill_cmd", cmd_log[s + 4 + i], {1'b0, 28'h204 + 28'(i)});
    for (int i = 0; i < 4; i++) check("t4_wb_mask", wm_log[ws + i], 16'hFFFF);
    check("t4_wb_beat0", wd_log[ws], {32'h1000_0013, 32'h1000_0012, 32'hCAFE_F00D, 32'h1000_0010});
    check("t4_wb_beat3", wd_log[ws + 3], {32'h1000_001F, 32'h1000_001E, 32'h1000_001D, 32'h1000_001C});
    access(30'h11, '0, 4'h0, rd, lat);
    check("t4_refetch", rd, 32'hCAFE_F00D);
    ddly = 0;
    s = cmd_log.size();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr = 30'h20;
    bus.cpu_req_write = 4'h0;
    n = 0;
    while (cmd_log.size() == s && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_first_fill", cmd_log[s], {1'b0, 28'h8});
    do_reset();
    check("t5_ready", bus.cpu_req_ready, 1'b1);
    check("t5_mem_valid", bus.mem_req_valid, 1'b0);
    check("t5_resp_valid", bus.cpu_resp_valid, 1'b0);
    access(30'h20, '0, 4'h0, rd, lat);
    check("t5_miss", 1'(lat > 2), 1'b1);
    check("t5_data", rd, 32'h1000_0020);
    access(30'h100, '0, 4'h0, rd, lat);
    check("t5_invalidated", 1'(lat > 2), 1'b1);
    check("t5_store_lost", rd, 32'h1000_0100);
`ifdef ASSOC_CACHE_STATS_EN
    do_reset();
    check("t6_clear", {stat_hits, stat_misses}, 64'h0);
    access(30'h100, '0, 4'h0, rd, lat);
    access(30'h100, '0, 4'h0, rd, lat);
    access(30'h101, '0, 4'h0, rd, lat);
    access(30'h102, 32'h1234_5678, 4'hF, rd, lat);
    access(30'h400, '0, 4'h0, rd, lat);
    check("t6_hits", stat_hits, 32'd3);
    check("t6_misses", stat_misses, 32'd2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
